save_uploader: RTL and testbench

//   Reverse direction of the ROM download path: streams bytes out of an on-chip
//   RAM (e.g. work RAM save area) to the HPS during an upload request.

---
 rtl/save_uploader.sv | 144 ++++++++++++++
 tb/tb_save_uploader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/save_uploader.sv
// Streams bytes from an on-chip RAM back to the HPS on upload requests,
// stalling the CPU while its upload index is active and tracking count/checksum.
module save_uploader #(
  parameter int         ADDR_W = 14,
  parameter logic [7:0] INDEX  = 8'd4,
  parameter logic [7:0] FILL   = 8'hFF
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic              up_req,
  input  logic [7:0]        up_index,
  input  logic [16:0]       up_addr,
  input  logic              up_rd,
  output logic [7:0]        up_din,
  output logic              up_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic [16:0]       up_count,
  output logic [7:0]        up_sum,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic                match_q, match_d;
  logic                oob_q, oob_d;
  logic [7:0]          up_din_q, up_din_d;
  logic                up_wait_q, up_wait_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic [16:0]         up_count_q, up_count_d;
  logic [7:0]          up_sum_q, up_sum_d;
  logic                overrun_q, overrun_d;

  logic                match;
  logic                start;
  logic                in_range;
  logic [7:0]          byte_val;

  always_comb begin
    match    = up_req && (up_index == INDEX);
    start    = match && !match_q;
    in_range = (32'(up_addr) < (32'd1 << ADDR_W));
    byte_val = oob_q ? FILL : mem_data;

    state_d    = state_q;
    match_d    = match;
    oob_d      = oob_q;
    up_din_d   = up_din_q;
    up_wait_d  = up_wait_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    cpu_hold_d = cpu_hold_q;
    up_count_d = up_count_q;
    up_sum_d   = up_sum_q;
    overrun_d  = overrun_q;

    if (start) begin
      up_count_d = 17'd0;
      up_sum_d   = 8'd0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (up_rd) begin
          if (match) begin
            state_d   = FETCH;
            up_wait_d = 1'b1;
            if (in_range) begin
              mem_addr_d = up_addr[ADDR_W-1:0];
              mem_rd_d   = 1'b1;
              oob_d      = 1'b0;
            end else begin
              oob_d = 1'b1;
            end
          end else begin
            up_din_d = FILL;
          end
        end
      end
      FETCH: begin
        state_d  = CAPTURE;
        mem_rd_d = 1'b0;
        if (up_rd) overrun_d = 1'b1;
      end
      CAPTURE: begin
        state_d    = IDLE;
        up_din_d   = byte_val;
        up_wait_d  = 1'b0;
        up_count_d = up_count_d + 17'd1;
        up_sum_d   = up_sum_d + byte_val;
        if (up_rd) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The hold is released only once any in-flight fetch has fully drained.
    if (match) cpu_hold_d = 1'b1;
    else if (state_q == IDLE) cpu_hold_d = 1'b0;
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      oob_q      <= 1'b0;
      up_din_q   <= FILL;
      up_wait_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      cpu_hold_q <= 1'b0;
      up_count_q <= 17'd0;
      up_sum_q   <= 8'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      oob_q      <= oob_d;
      up_din_q   <= up_din_d;
      up_wait_q  <= up_wait_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      cpu_hold_q <= cpu_hold_d;
      up_count_q <= up_count_d;
      up_sum_q   <= up_sum_d;
      overrun_q  <= overrun_d;
    end
  end

  assign up_din   = up_din_q;
  assign up_wait  = up_wait_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign cpu_hold = cpu_hold_q;
  assign up_count = up_count_q;
  assign up_sum   = up_sum_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_save_uploader.sv
// Bench for save_uploader: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_save_uploader;

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        up_req;
  logic [7:0]  up_index;
  logic [16:0] up_addr;
  logic        up_rd;
  logic [7:0]  up_din;
  logic        up_wait;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        cpu_hold;
  logic [16:0] up_count;
  logic [7:0]  up_sum;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:16383];

  save_uploader dut (
    .clk_24(clk_24), .reset(reset), .up_req(up_req), .up_index(up_index),
    .up_addr(up_addr), .up_rd(up_rd), .up_din(up_din), .up_wait(up_wait),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .up_count(up_count), .up_sum(up_sum), .overrun(overrun)
  );

  always #5 clk_24 = ~clk_24;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk_24) mem_data <= ram[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: an accepted request takes two busy cycles, and the byte
  // it will deliver is decided from the RAM image when the request is accepted.
  logic        m_valid = 1'b0;
  int          m_busy;
  logic        m_prev;
  logic [7:0]  m_byte;
  logic [7:0]  m_din;
  logic        m_wait;
  logic [13:0] m_addr;
  logic        m_rd;
  logic        m_hold;
  logic [16:0] m_count;
  logic [7:0]  m_sum;
  logic        m_over;

  always @(posedge clk_24) begin
    logic cur_match;
    logic was_busy;
    if (reset) begin
      m_din = 8'hFF; m_wait = 1'b0; m_addr = '0; m_rd = 1'b0; m_hold = 1'b0;
      m_count = '0; m_sum = '0; m_over = 1'b0; m_busy = 0; m_prev = 1'b0;
      m_byte = 8'hFF; m_valid = 1'b1;
    end else begin
      cur_match = up_req && (up_index == 8'd4);
      was_busy  = (m_busy != 0);
      if (cur_match && !m_prev) begin
        m_count = '0; m_sum = '0; m_over = 1'b0;
      end
      if (was_busy && up_rd) m_over = 1'b1;
      m_rd = 1'b0;
      if (m_busy == 1) begin
        m_din   = m_byte;
        m_count = m_count + 17'd1;
        m_sum   = m_sum + m_byte;
        m_busy  = 0;
      end else if (m_busy == 2) begin
        m_busy = 1;
      end else if (up_rd) begin
        if (cur_match) begin
          m_busy = 2;
          if (up_addr < 17'h04000) begin
            m_byte = ram[up_addr[13:0]];
            m_rd   = 1'b1;
            m_addr = up_addr[13:0];
          end else begin
            m_byte = 8'hFF;
          end
        end else begin
          m_din = 8'hFF;
        end
      end
      m_wait = (m_busy != 0);
      if (cur_match) m_hold = 1'b1;
      else if (!was_busy) m_hold = 1'b0;
      m_prev = cur_match;
    end
  end

  always @(negedge clk_24) begin
    if (m_valid) begin
      checkOutput("model up_din", 32'(up_din), 32'(m_din));
      checkOutput("model up_wait", 32'(up_wait), 32'(m_wait));
      checkOutput("model mem_addr", 32'(mem_addr), 32'(m_addr));
      checkOutput("model mem_rd", 32'(mem_rd), 32'(m_rd));
      checkOutput("model cpu_hold", 32'(cpu_hold), 32'(m_hold));
      checkOutput("model up_count", 32'(up_count), 32'(m_count));
      checkOutput("model up_sum", 32'(up_sum), 32'(m_sum));
      checkOutput("model overrun", 32'(overrun), 32'(m_over));
    end
  end

  task automatic applyStimulus(input logic req, input logic [7:0] idx,
                               input logic [16:0] addr, input logic rd);
    @(negedge clk_24);
    up_req   = req;
    up_index = idx;
    up_addr  = addr;
    up_rd    = rd;
  endtask

  task automatic readByte(input logic [16:0] addr, output int lat, output logic rd_seen);
    applyStimulus(1'b1, 8'd4, addr, 1'b1);
    applyStimulus(1'b1, 8'd4, addr, 1'b0);
    rd_seen = mem_rd;
    lat = 0;
    while (up_wait === 1'b1 && lat < 8) begin
      @(negedge clk_24);
      rd_seen = rd_seen | mem_rd;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    logic rd_seen;
    logic hold_all;

    for (int i = 0; i < 16384; i++) ram[i] = 8'(i) ^ 8'h33;
    ram[16'h0010] = 8'h5A;
    for (int i = 16'h0100; i < 16'h0200; i++) ram[i] = 8'h01;

    reset = 1'b1; up_req = 1'b0; up_index = 8'd0; up_addr = '0; up_rd = 1'b0;
    repeat (3) @(negedge clk_24);
    reset = 1'b0;
    checkOutput("reset up_din", 32'(up_din), 32'hFF);
    checkOutput("reset up_count", 32'(up_count), 32'd0);

    // Reset in the middle of a fetch.
    applyStimulus(1'b1, 8'd4, 17'h00020, 1'b1);
    applyStimulus(1'b1, 8'd4, 17'h00020, 1'b0);
    checkOutput("t1 mid-fetch up_wait", 32'(up_wait), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk_24);
    checkOutput("t1 up_wait", 32'(up_wait), 32'd0);
    checkOutput("t1 mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("t1 up_din", 32'(up_din), 32'hFF);
    checkOutput("t1 cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t1 up_count", 32'(up_count), 32'd0);
    reset = 1'b0;
    @(negedge clk_24);
    checkOutput("t1 mem_rd after", 32'(mem_rd), 32'd0);

    // Single byte fetch.
    readByte(17'h00010, lat, rd_seen);
    checkOutput("t2 latency", 32'(lat), 32'd2);
    checkOutput("t2 up_din", 32'(up_din), 32'h5A);
    checkOutput("t2 up_count", 32'(up_count), 32'd1);
    checkOutput("t2 up_sum", 32'(up_sum), 32'h5A);
    checkOutput("t2 mem_rd seen", 32'(rd_seen), 32'd1);

    // New upload, 256 bytes of 0x01.
    applyStimulus(1'b0, 8'd4, '0, 1'b0);
    applyStimulus(1'b0, 8'd4, '0, 1'b0);
    checkOutput("t3 hold dropped", 32'(cpu_hold), 32'd0);
    applyStimulus(1'b1, 8'd4, '0, 1'b0);
    hold_all = 1'b1;
    for (int i = 0; i < 256; i++) begin
      readByte(17'h00100 + 17'(i), lat, rd_seen);
      hold_all = hold_all & cpu_hold;
    end
    checkOutput("t3 up_count", 32'(up_count), 32'd256);
    checkOutput("t3 up_sum", 32'(up_sum), 32'h00);
    checkOutput("t3 hold throughout", 32'(hold_all), 32'd1);
    checkOutput("t3 hold before drop", 32'(cpu_hold), 32'd1);
    applyStimulus(1'b0, 8'd4, '0, 1'b0);
    @(negedge clk_24);
    checkOutput("t3 hold after drop", 32'(cpu_hold), 32'd0);

    // Out-of-range address.
    applyStimulus(1'b1, 8'd4, '0, 1'b0);
    readByte(17'h04000, lat, rd_seen);
    checkOutput("t4 latency", 32'(lat), 32'd2);
    checkOutput("t4 mem_rd seen", 32'(rd_seen), 32'd0);
    checkOutput("t4 up_din", 32'(up_din), 32'hFF);
    checkOutput("t4 up_count", 32'(up_count), 32'd1);

    // Non-matching index.
    readByte(17'h00010, lat, rd_seen);
    checkOutput("t5 pre up_din", 32'(up_din), 32'h5A);
    applyStimulus(1'b1, 8'd3, 17'h00010, 1'b1);
    applyStimulus(1'b1, 8'd3, 17'h00010, 1'b0);
    checkOutput("t5 up_din", 32'(up_din), 32'hFF);
    checkOutput("t5 mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("t5 cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("t5 up_count", 32'(up_count), 32'd2);

    // Match falls mid-fetch: fetch completes, then hold drops.
    applyStimulus(1'b1, 8'd4, 17'h00010, 1'b1);
    applyStimulus(1'b0, 8'd4, 17'h00010, 1'b0);
    repeat (2) @(negedge clk_24);
    checkOutput("tf up_din", 32'(up_din), 32'h5A);
    checkOutput("tf hold still", 32'(cpu_hold), 32'd1);
    @(negedge clk_24);
    checkOutput("tf hold released", 32'(cpu_hold), 32'd0);
    checkOutput("tf up_count", 32'(up_count), 32'd1);

    // Back-to-back request is ignored and flagged.
    applyStimulus(1'b1, 8'd4, 17'h00030, 1'b1);
    applyStimulus(1'b1, 8'd4, 17'h00040, 1'b1);
    applyStimulus(1'b1, 8'd4, 17'h00040, 1'b0);
    lat = 0;
    while (up_wait === 1'b1 && lat < 8) begin
      @(negedge clk_24);
      lat++;
    end
    checkOutput("t6 latency", 32'(lat), 32'd1);
    checkOutput("t6 up_din", 32'(up_din), 32'h03);
    checkOutput("t6 overrun", 32'(overrun), 32'd1);
    checkOutput("t6 up_count", 32'(up_count), 32'd1);
    applyStimulus(1'b0, 8'd4, '0, 1'b0);
    applyStimulus(1'b1, 8'd4, '0, 1'b0);
    applyStimulus(1'b1, 8'd4, '0, 1'b0);
    checkOutput("t6 overrun cleared", 32'(overrun), 32'd0);
    checkOutput("t6 count cleared", 32'(up_count), 32'd0);
    checkOutput("t6 sum cleared", 32'(up_sum), 32'd0);

    repeat (2) @(negedge clk_24);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
